// File: rtl/regwb_pkg.sv
// regwb_pkg: shared types and helpers for the register write-back queue.
//   REG_ZR        - register index that always reads as zero (writes are dropped)
//   regwb_entry_t - one pending register write: {valid, addr, data}
//   ptr_inc       - pointer increment modulo the queue depth
package regwb_pkg;

  localparam int REGWB_ADDR_W = 5;
  localparam int REGWB_DATA_W = 64;

  localparam logic [REGWB_ADDR_W-1:0] REG_ZR = 5'd31;

  typedef struct packed {
    logic                    valid;
    logic [REGWB_ADDR_W-1:0] addr;
    logic [REGWB_DATA_W-1:0] data;
  } regwb_entry_t;

  function automatic int unsigned ptr_inc(input int unsigned p, input int unsigned depth);
    return (p + 1) % depth;
  endfunction

endpackage

// File: rtl/regwb_bypass_match.sv
// regwb_bypass_match: combinational lookup of the youngest pending write to
// a register, so operand reads observe writes still sitting in the queue.
//   ent      - queue storage (valid entries are contiguous starting at head)
//   head     - index of the oldest entry
//   byp_addr - register being read
//   byp_hit  - some valid entry targets byp_addr
//   byp_data - data of the youngest matching entry, 0 on miss
module regwb_bypass_match
  import regwb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  regwb_entry_t            ent [DEPTH],
  input  logic [PTR_W-1:0]        head,
  input  logic [REGWB_ADDR_W-1:0] byp_addr,
  output logic                    byp_hit,
  output logic [REGWB_DATA_W-1:0] byp_data
);

  logic [PTR_W-1:0] idx;

  // Walk oldest to youngest and let later matches override earlier ones.
  // DEPTH is a power of two, so the PTR_W-bit add wraps for free.
  always_comb begin
    byp_hit  = 1'b0;
    byp_data = '0;
    idx      = head;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if (ent[idx].valid && ent[idx].addr == byp_addr && byp_addr != REG_ZR) begin
        byp_hit  = 1'b1;
        byp_data = ent[idx].data;
      end
    end
  end

endmodule

// File: rtl/regwb_queue.sv
// regwb_queue: in-order write-back buffer feeding the register-file write port.
//   clk, reset_n                 - clock, async active-low reset
//   in_valid/in_ready            - request handshake (in_ready = !full)
//   in_addr/in_data              - destination register and data; writes to
//                                  REG_ZR complete the handshake but are dropped
//   drain_en                     - write port free this cycle
//   wr_en/wr_addr/wr_data        - head entry presented to the regfile decoder
//   byp_addr/byp_hit/byp_data    - read bypass against pending writes
//   busy                         - queue non-empty
module regwb_queue
  import regwb_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = REGWB_ADDR_W,  // entry struct is sized from the package
  parameter int DATA_W = REGWB_DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              drain_en,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] byp_addr,
  output logic              byp_hit,
  output logic [DATA_W-1:0] byp_data,
  output logic              busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  regwb_entry_t     ent [DEPTH];
  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] count;
  logic             full, push, pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign busy     = (count != '0);
  // in_ready ignores a same-cycle pop: no push-through when full.
  assign in_ready = !full;
  assign push     = in_valid && in_ready && (in_addr != REG_ZR);
  assign pop      = wr_en;

  // Purely from registered state + drain_en, so an async reset drops it at once.
  assign wr_en   = busy && drain_en;
  assign wr_addr = busy ? ent[head].addr : '0;
  assign wr_data = busy ? ent[head].data : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
    end else begin
      // head == tail with both active is impossible: that needs empty (no pop)
      // or full (no push).
      if (push) begin
        ent[tail].valid <= 1'b1;
        ent[tail].addr  <= in_addr;
        ent[tail].data  <= in_data;
        tail <= PTR_W'(ptr_inc(32'(tail), DEPTH));
      end
      if (pop) begin
        ent[head].valid <= 1'b0;
        head <= PTR_W'(ptr_inc(32'(head), DEPTH));
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  regwb_bypass_match #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_byp (
    .ent      (ent),
    .head     (head),
    .byp_addr (byp_addr),
    .byp_hit  (byp_hit),
    .byp_data (byp_data)
  );

endmodule

// File: tb/tb_regwb_queue.sv
module tb_regwb_queue;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 64;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } req_t;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [ADDR_W-1:0] in_addr = '0;
  logic [DATA_W-1:0] in_data = '0;
  logic              drain_en = 1'b0;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] byp_addr = '0;
  logic              byp_hit;
  logic [DATA_W-1:0] byp_data;
  logic              busy;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: pending writes in acceptance order, front = oldest.
  req_t exp_q[$];

  regwb_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
    .drain_en(drain_en), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .byp_addr(byp_addr), .byp_hit(byp_hit), .byp_data(byp_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every falling edge compare DUT outputs to the model. A write that
  // wr_en announces here is retired from the model (it lands at the next rise).
  always @(negedge clk) begin
    logic             m_hit;
    logic [DATA_W-1:0] m_data;
    m_hit = 1'b0; m_data = '0;
    if (byp_addr != 5'd31)
      for (int i = 0; i < exp_q.size(); i++)
        if (exp_q[i].addr == byp_addr) begin m_hit = 1'b1; m_data = exp_q[i].data; end
    check("busy", 64'(busy), 64'(exp_q.size() != 0));
    check("in_ready", 64'(in_ready), 64'(exp_q.size() < DEPTH));
    check("wr_en", 64'(wr_en), 64'(exp_q.size() != 0 && drain_en));
    check("byp_hit", 64'(byp_hit), 64'(m_hit));
    check("byp_data", byp_data, m_data);
    if (exp_q.size() == 0) begin
      check("wr_addr_empty", 64'(wr_addr), 64'd0);
      check("wr_data_empty", wr_data, 64'd0);
    end else begin
      check("wr_addr", 64'(wr_addr), 64'(exp_q[0].addr));
      check("wr_data", wr_data, exp_q[0].data);
      if (drain_en) void'(exp_q.pop_front());
    end
  end

  // Offer one request and hold it stable until accepted (bounded).
  task automatic push(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    logic acc;
    int   n;
    in_valid = 1'b1; in_addr = a; in_data = d;
    acc = 1'b0; n = 0;
    while (!acc && n < 200) begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); n++;
    end
    if (!acc) begin
      n_vec++; n_err++;
      $display("FAIL push_timeout: addr %0d never accepted", a);
    end else if (a != 5'd31) begin
      exp_q.push_back('{addr: a, data: d});
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic drain_all();
    int n = 0;
    drain_en = 1'b1;
    while (exp_q.size() != 0 && n < 100) begin @(posedge clk); n++; end
    check("drain_done", 64'(exp_q.size()), 64'd0);
    #1;
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_wr_en", 64'(wr_en), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_byp_hit", 64'(byp_hit), 64'd0);
    @(posedge clk); #1 reset_n = 1'b1;

    // Single write then drain
    drain_en = 1'b1;
    push(5, 64'hDEAD);
    @(posedge clk); #1;
    check("single_busy_after", 64'(busy), 64'd0);

    // Fill and stall, fifth request held until space opens
    drain_en = 1'b0;
    for (int i = 1; i <= 4; i++) push(ADDR_W'(i), 64'(100 + i));
    check("full_in_ready", 64'(in_ready), 64'd0);
    fork
      push(6, 64'h66);
      begin repeat (3) @(posedge clk); #2 drain_en = 1'b1; end
    join
    drain_all();

    // XZR drop
    byp_addr = 5'd31;
    push(31, 64'hFF);
    #1;
    check("xzr_busy", 64'(busy), 64'd0);
    check("xzr_byp_hit", 64'(byp_hit), 64'd0);

    // Bypass youngest match
    drain_en = 1'b0; byp_addr = 5'd7;
    push(7, 64'h10);
    push(7, 64'h20);
    check("byp_young_hit", 64'(byp_hit), 64'd1);
    check("byp_young_data", byp_data, 64'h20);
    drain_en = 1'b1; @(posedge clk); #1 drain_en = 1'b0;
    check("byp_after1_data", byp_data, 64'h20);
    drain_en = 1'b1; @(posedge clk); #1;
    check("byp_after2_hit", 64'(byp_hit), 64'd0);

    // Back-to-back with drain: pointers wrap, order preserved
    byp_addr = 5'd3;
    for (int i = 0; i < 10; i++) push(ADDR_W'(i % 8), 64'(i));
    drain_all();

    // Async reset mid-drain
    drain_en = 1'b0; byp_addr = 5'd2;
    push(1, 64'hA1); push(2, 64'hA2); push(3, 64'hA3);
    #1 drain_en = 1'b1;
    #1 check("pre_rst_wr_en", 64'(wr_en), 64'd1);
    reset_n = 1'b0; exp_q.delete();
    #1;
    check("async_rst_wr_en", 64'(wr_en), 64'd0);
    check("async_rst_busy", 64'(busy), 64'd0);
    check("async_rst_byp", 64'(byp_hit), 64'd0);
    @(posedge clk); #1 reset_n = 1'b1;
    push(9, 64'h99);
    #1 check("post_rst_first_addr", 64'(wr_addr), 64'd9);
    drain_all();

    // Randomized traffic
    begin
      logic             pend, acc;
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
      pend = 1'b0; a = '0; d = '0;
      for (int c = 0; c < 400; c++) begin
        drain_en = ($urandom_range(0, 3) != 0);
        byp_addr = ($urandom_range(0, 1) != 0) ? ADDR_W'($urandom_range(0, 7))
                                                : ADDR_W'($urandom_range(24, 31));
        if (!pend && $urandom_range(0, 2) != 0) begin
          pend = 1'b1;
          a = ($urandom_range(0, 9) == 0) ? 5'd31 : ADDR_W'($urandom_range(0, 7));
          d = {$urandom, $urandom};
        end
        in_valid = pend; in_addr = a; in_data = d;
        @(negedge clk); acc = pend && in_ready;
        @(posedge clk);
        if (acc) begin
          if (a != 5'd31) exp_q.push_back('{addr: a, data: d});
          pend = 1'b0;
        end
        #1;
      end
      in_valid = 1'b0;
    end
    drain_all();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/regwb_queue.md
Name: regwb_queue

Overview:
- Write-back buffer between the execute/memory stages and the register-file write port.
- Accepts register write requests with a valid/ready handshake and holds up to DEPTH of them in order.
- Drains one request per cycle into the register-file write decoder: wr_en drives the decoder enable, wr_addr drives its select.
- Provides a read-bypass lookup so operand reads see writes still pending in the queue.

Parameters:
- DEPTH, 4, queue entries; power of 2, at least 2.
- ADDR_W, 5, register index width (32 registers; index 31 is XZR).
- DATA_W, 64, register data width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  write request present.
- in_ready  output  1  queue can accept a request; equals !full.
- in_addr  input  ADDR_W  destination register index.
- in_data  input  DATA_W  write data.
- drain_en  input  1  register-file write port available this cycle.
- wr_en  output  1  register-file write strobe; goes to the decoder enable.
- wr_addr  output  ADDR_W  head entry register index; goes to the decoder select.
- wr_data  output  DATA_W  head entry data.
- byp_addr  input  ADDR_W  operand register being read.
- byp_hit  output  1  a pending entry targets byp_addr.
- byp_data  output  DATA_W  data of the youngest matching pending entry.
- busy  output  1  queue non-empty.

Behaviour:
- Reset (async assert, sync release):
  - head and tail pointers = 0, count = 0, all entry valid bits = 0.
  - Outputs: in_ready=1, wr_en=0, busy=0, byp_hit=0. wr_addr, wr_data and byp_data = 0 while empty.
- Push:
  - Occurs when in_valid && in_ready && in_addr != 31.
  - Writes {addr, data} at tail; tail <= tail+1 mod DEPTH.
- XZR drop:
  - in_valid && in_ready && in_addr == 31 is accepted (handshake completes) but not enqueued.
  - count unchanged; no wr_en ever results.
- Pop:
  - wr_en = busy && drain_en, combinational from registered state and drain_en only.
  - When wr_en=1, the entry is written to the register file at that edge; head <= head+1 mod DEPTH.
- Latency: request accepted into an empty queue at edge N gives wr_en=1 in cycle N+1, provided drain_en=1. No same-cycle pass-through.
- Ordering: strict FIFO. Writes to the same register drain in acceptance order.
- Simultaneous push and pop:
  - Allowed when not full; count unchanged; both pointers advance.
  - When full, in_ready=0 even if a pop happens in the same cycle. No push-through-full.
- Count: 0..DEPTH, width clog2(DEPTH)+1. full = (count == DEPTH). busy = (count != 0).
- Wrap-around: pointers wrap modulo DEPTH. A correct sequence of 2*DEPTH pushes and pops keeps order.
- in_valid while full: request is held off. Upstream keeps in_addr and in_data stable until in_ready=1.
- drain_en=0: queue holds contents; wr_en=0; wr_addr and wr_data still show the head entry.
- Bypass (combinational):
  - Search all valid entries for addr == byp_addr and pick the youngest (closest to tail).
  - byp_addr == 31 always gives byp_hit=0 and byp_data=0.
  - The entry being popped this cycle still counts as a hit. The entry being pushed this cycle does not count.
  - No hit gives byp_data=0.
- Reset mid-operation: all pending entries are discarded immediately and asynchronously. wr_en falls to 0 without waiting for a clock edge.

Decomposition:
- Package regwb_pkg:
  - REG_ZR = 5'd31.
  - typedef regwb_entry_t = struct {valid, addr[ADDR_W], data[DATA_W]}.
  - Helper function ptr_inc (modulo DEPTH).
- One sub-module, regwb_bypass_match:
  - Inputs: entry array, head pointer, byp_addr.
  - Outputs: byp_hit, byp_data.
  - Youngest-first priority search, combinational.
- Top level owns the pointers, count, storage and handshake.

Test Plan:
- Reset then single write: push addr=5, data=0xDEAD at edge 1 with drain_en=1 -> wr_en=1, wr_addr=5, wr_data=0xDEAD in cycle 2; busy=0 in cycle 3.
- Fill and stall: drain_en=0, push addrs 1,2,3,4 -> in_ready=0 after the 4th; a 5th request (addr 6) is held; raise drain_en -> wr_addr sequence 1,2,3,4,6 on consecutive cycles.
- XZR drop: push addr=31, data=0xFF with in_ready=1 -> handshake completes, count stays 0, wr_en never asserts; bypass of 31 -> byp_hit=0.
- Bypass youngest: drain_en=0, push (7,0x10) then (7,0x20); byp_addr=7 -> byp_hit=1, byp_data=0x20. After one pop, still 0x20. After two pops, byp_hit=0.
- Simultaneous push and pop with wrap: 10 back-to-back requests with drain_en=1 and data = i -> count never exceeds 1, wr_data sequence 0..9 in order, pointers wrap twice.
- Async reset mid-drain: 3 entries queued, assert reset_n=0 between edges -> wr_en=0 and busy=0 immediately. After release, a new push of addr=9 drains as the first write.
